// File: rtl/result_dst_pipe.sv
// Destination-register pipeline with per-register pending-write counters.
// Instructions reading a register that still has an in-flight write are held off via hazard.
module result_dst_pipe #(
    parameter int AW    = 2,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [AW-1:0]                RIn1,
    input  logic [AW-1:0]                RIn2,
    input  logic [AW-1:0]                D,
    input  logic [1:0]                   DstType,
    input  logic                         flush,
    output logic                         hazard,
    output logic                         accept,
    output logic                         out_valid,
    output logic                         out_we,
    output logic [AW-1:0]                out_dst,
    output logic [$clog2(DEPTH+1)-1:0]   inflight
);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int NREG = 2 ** AW;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] we_q, we_d;
    logic [AW-1:0]    dst_q [DEPTH];
    logic [AW-1:0]    dst_d [DEPTH];
    logic [CW-1:0]    cnt_q [NREG];
    logic [CW-1:0]    cnt_d [NREG];

    logic             dec_we;
    logic [AW-1:0]    dec_dst;

    always_comb begin
        dec_we  = 1'b1;
        dec_dst = RIn1;
        case (DstType)
            2'b00:   dec_dst = RIn1;
            2'b01:   dec_dst = ~(RIn1 | RIn2);
            2'b10:   dec_dst = D;
            default: begin
                dec_dst = '0;
                dec_we  = 1'b0;
            end
        endcase
    end

    assign hazard = in_valid & ((cnt_q[RIn1] != '0) | (cnt_q[RIn2] != '0));
    assign accept = in_valid & ~hazard & ~flush;

    assign out_valid = valid_q[DEPTH-1];
    assign out_we    = we_q[DEPTH-1];
    assign out_dst   = dst_q[DEPTH-1];

    // Stage 1 carries zeros for we/dst when empty, so the output stage is clean when invalid.
    always_comb begin
        valid_d[0] = accept;
        we_d[0]    = accept & dec_we;
        dst_d[0]   = accept ? dec_dst : '0;
        for (int k = 1; k < DEPTH; k++) begin
            valid_d[k] = valid_q[k-1];
            we_d[k]    = we_q[k-1];
            dst_d[k]   = dst_q[k-1];
        end
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (accept && dec_we && (dec_dst == AW'(r)))
                cnt_d[r] = cnt_d[r] + CW'(1);
            if (out_valid && out_we && (out_dst == AW'(r)))
                cnt_d[r] = cnt_d[r] - CW'(1);
        end
        if (flush) begin
            valid_d = '0;
            we_d    = '0;
            for (int k = 0; k < DEPTH; k++) dst_d[k] = '0;
            for (int r = 0; r < NREG; r++) cnt_d[r] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            we_q    <= '0;
            for (int k = 0; k < DEPTH; k++) dst_q[k] <= '0;
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
        end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            for (int k = 0; k < DEPTH; k++) dst_q[k] <= dst_d[k];
            for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    always_comb begin
        inflight = '0;
        for (int k = 0; k < DEPTH; k++)
            inflight = inflight + CW'(valid_q[k]);
    end

endmodule

// File: tb/tb_result_dst_pipe.sv
// Randomized scoreboard bench for result_dst_pipe against an in-flight list reference model.
module tb_result_dst_pipe;
    localparam int AW    = 2;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0]   cyc;
        logic          we;
        logic [AW-1:0] dst;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [AW-1:0] RIn1 = '0, RIn2 = '0, D = '0;
    logic [1:0]    DstType = '0;
    logic          flush = 1'b0;
    logic          hazard, accept, out_valid, out_we;
    logic [AW-1:0] out_dst;
    logic [CW-1:0] inflight;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    ent_t exp_q[$];
    ent_t pend_q[$];

    result_dst_pipe #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .RIn1(RIn1), .RIn2(RIn2),
        .D(D), .DstType(DstType), .flush(flush), .hazard(hazard), .accept(accept),
        .out_valid(out_valid), .out_we(out_we), .out_dst(out_dst), .inflight(inflight)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Entry accepted in cycle c is in flight during cycles c+1 .. c+DEPTH.
    function automatic void purge_model();
        while (pend_q.size() > 0 && int'(pend_q[0].cyc) < cyc) void'(pend_q.pop_front());
    endfunction

    function automatic bit pending(input logic [AW-1:0] r);
        foreach (pend_q[i]) if (pend_q[i].we && pend_q[i].dst == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic cycle(input bit iv, input int r1, input int r2, input int d,
                         input int dt, input bit fl, output bit acc_exp);
        logic [AW-1:0] a, b, e_dst;
        bit            e_haz;
        ent_t          ent;
        @(negedge clk);
        in_valid = iv; RIn1 = AW'(r1); RIn2 = AW'(r2); D = AW'(d);
        DstType = 2'(dt); flush = fl;
        #1;
        purge_model();
        a = AW'(r1); b = AW'(r2);
        e_haz   = iv && (pending(a) || pending(b));
        acc_exp = iv && !e_haz && !fl;
        chk("hazard", int'(hazard), int'(e_haz));
        chk("accept", int'(accept), int'(acc_exp));
        chk("inflight", int'(inflight), pend_q.size());
        if (acc_exp) begin
            case (dt)
                0:       e_dst = a;
                1:       e_dst = ~(a | b);
                2:       e_dst = AW'(d);
                default: e_dst = '0;
            endcase
            ent.cyc = 32'(cyc + DEPTH);
            ent.we  = (dt != 3);
            ent.dst = e_dst;
            exp_q.push_back(ent);
            pend_q.push_back(ent);
        end
        if (fl) begin
            @(posedge clk);
            #1;
            exp_q.delete();
            pend_q.delete();
        end
    endtask

    // Output monitor: compares every presented writeback against the scoreboard.
    always @(negedge clk) begin
        #2;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                chk("out_cycle", cyc, int'(e.cyc));
                chk("out_we", int'(out_we), int'(e.we));
                chk("out_dst", int'(out_dst), int'(e.dst));
            end
        end else begin
            chk("idle_out_we", int'(out_we), 0);
            chk("idle_out_dst", int'(out_dst), 0);
        end
    end

    initial begin
        bit acc;
        int tries;

        #3;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_inflight", int'(inflight), 0);
        chk("rst_hazard", int'(hazard), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency with DstType 00.
        cycle(1, 2, 0, 0, 0, 0, acc);
        chk("lat_accept", int'(acc), 1);
        cycle(0, 0, 0, 0, 0, 0, acc);
        cycle(0, 0, 0, 0, 0, 0, acc);
        cycle(0, 0, 0, 0, 0, 0, acc);

        // NOR destination mode.
        cycle(1, 1, 0, 0, 1, 0, acc);
        cycle(1, 3, 0, 0, 1, 0, acc);
        repeat (3) cycle(0, 0, 0, 0, 0, 0, acc);

        // Hazard on r3, re-presented until accepted.
        cycle(1, 0, 0, 3, 2, 0, acc);
        cycle(1, 3, 3, 0, 0, 0, acc);
        chk("hz_blocked", int'(acc), 0);
        tries = 0;
        while (!acc && tries < 8) begin
            cycle(1, 3, 3, 0, 0, 0, acc);
            tries++;
        end
        chk("hz_eventually_accepted", int'(acc), 1);
        repeat (3) cycle(0, 0, 0, 0, 0, 0, acc);

        // No-write entry leaves counters untouched.
        cycle(1, 0, 0, 0, 3, 0, acc);
        cycle(1, 0, 0, 0, 0, 0, acc);
        chk("nowrite_no_hazard", int'(acc), 1);
        repeat (3) cycle(0, 0, 0, 0, 0, 0, acc);

        // Flush with r1, r2 in flight.
        cycle(1, 0, 0, 1, 2, 0, acc);
        cycle(1, 0, 0, 2, 2, 0, acc);
        cycle(1, 0, 0, 0, 0, 1, acc);
        chk("flush_accept", int'(acc), 0);
        cycle(1, 1, 1, 0, 3, 0, acc);
        chk("after_flush_r1_free", int'(acc), 1);
        repeat (3) cycle(0, 0, 0, 0, 0, 0, acc);

        // Asynchronous reset with two entries in flight.
        cycle(1, 0, 0, 1, 2, 0, acc);
        cycle(1, 0, 0, 2, 2, 0, acc);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("pre_rst_inflight", int'(inflight), 2);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", int'(out_valid), 0);
        chk("async_rst_inflight", int'(inflight), 0);
        exp_q.delete();
        pend_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 24) == 0, acc);
        end
        repeat (DEPTH + 2) cycle(0, 0, 0, 0, 0, 0, acc);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
